// File: rtl/game_pkg.sv
// Shared state encoding, level limits and speed-tier thresholds for the game controller.
// Latency/backpressure: none, declarations only.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_HIT       = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_e;

   localparam int unsigned MAX_LEVEL = 99;
   localparam int unsigned SPEED_T1  = 5;
   localparam int unsigned SPEED_T2  = 10;
   localparam int unsigned SPEED_T3  = 20;
   localparam int unsigned TIMER_W   = 8;

   function automatic logic [1:0] speed_tier(input logic [6:0] level);
      logic [1:0] tier;
      if (level >= 7'(SPEED_T3))      tier = 2'd3;
      else if (level >= 7'(SPEED_T2)) tier = 2'd2;
      else if (level >= 7'(SPEED_T1)) tier = 2'd1;
      else                            tier = 2'd0;
      return tier;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Counts frame ticks while enabled; flags the terminal tick and every 8th tick.
// Strobes are combinational from the tick of the current cycle; no backpressure.
module frame_timer
   import game_pkg::*;
#(
   parameter int unsigned W = TIMER_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic         tick_i,
   input  logic [W-1:0] limit_i,
   output logic         done_o,
   output logic         octet_o
);

   logic [W-1:0] count_q, count_d;
   logic         counting;

   assign counting = en_i && tick_i && !clear_i;

   always_comb begin
      count_d = count_q;
      if (clear_i)       count_d = '0;
      else if (counting) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   // done fires on the tick that brings the count up to limit_i
   assign done_o  = counting && (count_q == limit_i - 1'b1);
   assign octet_o = counting && (count_q[2:0] == 3'b111);

endmodule

// File: rtl/game_controller.sv
// Game sequencing FSM: IDLE/PLAY/HIT/LEVEL_UP/GAME_OVER with lives, level and speed tier.
// All outputs registered; start edge acts 3 cycles after the raw switch rises; no backpressure.
module game_controller
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INIT = 3,
   parameter int unsigned HIT_FRAMES = 60,
   parameter int unsigned WIN_FRAMES = 30,
   parameter int unsigned GOAL_ROW   = 1
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_frame_tick,
   input  logic       i_start,
   input  logic       i_collision,
   input  logic [3:0] i_player_y,
   output logic [2:0] o_state,
   output logic [6:0] o_level,
   output logic [1:0] o_lives,
   output logic       o_player_reset,
   output logic       o_car_enable,
   output logic [1:0] o_speed_sel,
   output logic       o_flash
);

   localparam logic [1:0]         LIVES_RST = 2'(LIVES_INIT);
   localparam logic [TIMER_W-1:0] HIT_LIM   = TIMER_W'(HIT_FRAMES);
   localparam logic [TIMER_W-1:0] WIN_LIM   = TIMER_W'(WIN_FRAMES);

   logic   start_s1_q, start_s2_q, start_s3_q;
   logic   start_edge;
   state_e state_q;
   logic [6:0] level_q;
   logic [1:0] lives_q;
   logic       player_reset_q, car_en_q, flash_q;
   logic [1:0] speed_q;

   logic [6:0] level_d;
   logic [1:0] lives_d;
   logic       goal;
   logic       timer_en, timer_clear, timer_done, timer_octet;
   logic [TIMER_W-1:0] timer_limit;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         start_s3_q <= 1'b0;
      end else begin
         start_s1_q <= i_start;
         start_s2_q <= start_s1_q;
         start_s3_q <= start_s2_q;
      end
   end

   assign start_edge = start_s2_q && !start_s3_q;
   assign goal       = (i_player_y == 4'(GOAL_ROW));
   assign level_d    = (level_q == 7'(MAX_LEVEL)) ? 7'd0 : level_q + 7'd1;
   assign lives_d    = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;

   // The counter sits at zero outside HIT/LEVEL_UP, so it is clear on entry.
   assign timer_en    = (state_q == ST_HIT) || (state_q == ST_LEVEL_UP);
   assign timer_clear = !timer_en;
   assign timer_limit = (state_q == ST_HIT) ? HIT_LIM : WIN_LIM;

   frame_timer #(.W(TIMER_W)) u_frame_timer (
      .clk_i   (i_Clk),
      .rst_ni  (i_Rst_n),
      .clear_i (timer_clear),
      .en_i    (timer_en),
      .tick_i  (i_frame_tick),
      .limit_i (timer_limit),
      .done_o  (timer_done),
      .octet_o (timer_octet)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q        <= ST_IDLE;
         level_q        <= 7'd0;
         lives_q        <= LIVES_RST;
         player_reset_q <= 1'b0;
         car_en_q       <= 1'b0;
         flash_q        <= 1'b0;
         speed_q        <= 2'd0;
      end else begin
         player_reset_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               level_q  <= 7'd0;
               lives_q  <= LIVES_RST;
               speed_q  <= 2'd0;
               flash_q  <= 1'b0;
               car_en_q <= 1'b0;
               if (start_edge) begin
                  state_q        <= ST_PLAY;
                  player_reset_q <= 1'b1;
                  car_en_q       <= 1'b1;
               end
            end
            ST_PLAY: begin
               // collision wins over reaching the goal row in the same cycle
               if (i_collision) begin
                  state_q  <= ST_HIT;
                  lives_q  <= lives_d;
                  car_en_q <= 1'b0;
                  flash_q  <= 1'b1;
               end else if (goal) begin
                  state_q  <= ST_LEVEL_UP;
                  level_q  <= level_d;
                  speed_q  <= speed_tier(level_d);
                  car_en_q <= 1'b0;
               end
            end
            ST_HIT: begin
               if (timer_done) begin
                  flash_q <= 1'b0;
                  if (lives_q == 2'd0) begin
                     state_q <= ST_GAME_OVER;
                  end else begin
                     state_q        <= ST_PLAY;
                     player_reset_q <= 1'b1;
                     car_en_q       <= 1'b1;
                  end
               end else if (timer_octet) begin
                  flash_q <= !flash_q;
               end
            end
            ST_LEVEL_UP: begin
               if (timer_done) begin
                  state_q        <= ST_PLAY;
                  player_reset_q <= 1'b1;
                  car_en_q       <= 1'b1;
               end
            end
            ST_GAME_OVER: begin
               lives_q  <= 2'd0;
               car_en_q <= 1'b0;
               if (start_edge) begin
                  state_q <= ST_IDLE;
                  level_q <= 7'd0;
                  lives_q <= LIVES_RST;
                  speed_q <= 2'd0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               car_en_q <= 1'b0;
               flash_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_state        = state_q;
   assign o_level        = level_q;
   assign o_lives        = lives_q;
   assign o_player_reset = player_reset_q;
   assign o_car_enable   = car_en_q;
   assign o_speed_sel    = speed_q;
   assign o_flash        = flash_q;

endmodule
